// File: rtl/lcd_write_ctrl_if.sv
// Receiver-buffer pop handshake plus the HD44780 8-bit write bus, bundled for the LCD write controller.
interface lcd_write_ctrl_if;
    logic       data_ready;
    logic [7:0] rx_data;
    logic       overrun_error;
    logic       data_read;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_en;
    logic [7:0] lcd_data;
    logic       busy;

    modport master (
        input  data_ready, rx_data, overrun_error,
        output data_read, lcd_rs, lcd_rw, lcd_en, lcd_data, busy
    );

    modport slave (
        output data_ready, rx_data, overrun_error,
        input  data_read, lcd_rs, lcd_rw, lcd_en, lcd_data, busy
    );
endinterface

// File: rtl/lcd_write_ctrl.sv
// Purpose: runs HD44780 init, then pops receiver bytes and writes them as chars with wrap/clear (LCD_CTRL_ERR_CHAR_EN adds '!' on overrun).
// Latency: data_ready in IDLE cycle N -> data_read N+1, lcd_en N+3..N+2+EN_CYCLES, idle after hold.
// Backpressure: data_ready is sampled only in IDLE; bytes wait in the receiver buffer while busy.
module lcd_write_ctrl #(
    parameter int unsigned POWERUP_CYCLES = 40000,
    parameter int unsigned EN_CYCLES      = 8,
    parameter int unsigned CMD_CYCLES     = 400,
    parameter int unsigned CLEAR_CYCLES   = 16000,
    parameter int unsigned COLS           = 16
) (
    input  logic             clk,
    input  logic             n_rst,
    lcd_write_ctrl_if.master bus
);

    localparam int unsigned MAX_A   = (POWERUP_CYCLES > CLEAR_CYCLES) ? POWERUP_CYCLES : CLEAR_CYCLES;
    localparam int unsigned MAX_B   = (EN_CYCLES > CMD_CYCLES) ? EN_CYCLES : CMD_CYCLES;
    localparam int unsigned CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int          CNT_W   = $clog2(CNT_MAX) + 1;
    localparam int          COL_W   = $clog2(COLS) + 1;

    typedef enum logic [2:0] {
        POWER_WAIT,
        INIT_LOAD,
        IDLE,
        ACCEPT,
        SETUP,
        PULSE,
        HOLD,
        WRAP_LOAD
    } state_t;

    // What the transfer engine returns to once HOLD expires.
    typedef enum logic [1:0] {
        XF_INIT,
        XF_CHAR,
        XF_CMD
    } xfer_t;

    state_t           state_q, state_d;
    xfer_t            xfer_q, xfer_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [COL_W-1:0] col_q, col_d;
    logic             line_q, line_d;
    logic             rs_q, rs_d;
    logic [7:0]       dat_q, dat_d;
    logic [CNT_W-1:0] hold_last;
    logic             err_pend;

    function automatic logic [7:0] init_cmd(input logic [1:0] i);
        case (i)
            2'd0:    init_cmd = 8'h38;
            2'd1:    init_cmd = 8'h0C;
            2'd2:    init_cmd = 8'h01;
            default: init_cmd = 8'h06;
        endcase
    endfunction

`ifdef LCD_CTRL_ERR_CHAR_EN
    logic ovr_q;
    logic pend_q;
    logic err_take;

    // Clearing and a fresh edge can coincide; the edge wins so it is never dropped.
    assign err_take = (state_q == IDLE) && pend_q;
    assign err_pend = pend_q;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            ovr_q  <= 1'b0;
            pend_q <= 1'b0;
        end else begin
            ovr_q  <= bus.overrun_error;
            pend_q <= (pend_q && !err_take) || (bus.overrun_error && !ovr_q);
        end
    end
`else
    logic unused_overrun;
    assign unused_overrun = bus.overrun_error;
    assign err_pend       = 1'b0;
`endif

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= POWER_WAIT;
            xfer_q  <= XF_INIT;
            cnt_q   <= '0;
            idx_q   <= '0;
            col_q   <= '0;
            line_q  <= 1'b0;
            rs_q    <= 1'b0;
            dat_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            xfer_q  <= xfer_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            col_q   <= col_d;
            line_q  <= line_d;
            rs_q    <= rs_d;
            dat_q   <= dat_d;
        end
    end

    assign hold_last = (!rs_q && dat_q == 8'h01) ? CNT_W'(CLEAR_CYCLES - 1) : CNT_W'(CMD_CYCLES - 1);

    always_comb begin
        state_d = state_q;
        xfer_d  = xfer_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        col_d   = col_q;
        line_d  = line_q;
        rs_d    = rs_q;
        dat_d   = dat_q;

        case (state_q)
            POWER_WAIT: begin
                if (cnt_q == CNT_W'(POWERUP_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = INIT_LOAD;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            INIT_LOAD: begin
                rs_d    = 1'b0;
                dat_d   = init_cmd(idx_q);
                xfer_d  = XF_INIT;
                state_d = SETUP;
            end
            IDLE: begin
                if (err_pend) begin
                    rs_d    = 1'b1;
                    dat_d   = 8'h21;
                    xfer_d  = XF_CHAR;
                    state_d = SETUP;
                end else if (bus.data_ready) begin
                    state_d = ACCEPT;
                end
            end
            ACCEPT: begin
                // Form-feed becomes clear-display; the cursor homes along with DDRAM.
                if (bus.rx_data == 8'h0C) begin
                    rs_d   = 1'b0;
                    dat_d  = 8'h01;
                    xfer_d = XF_CMD;
                    col_d  = '0;
                    line_d = 1'b0;
                end else begin
                    rs_d   = 1'b1;
                    dat_d  = bus.rx_data;
                    xfer_d = XF_CHAR;
                end
                state_d = SETUP;
            end
            SETUP: begin
                cnt_d   = '0;
                state_d = PULSE;
            end
            PULSE: begin
                if (cnt_q == CNT_W'(EN_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HOLD: begin
                if (cnt_q == hold_last) begin
                    cnt_d = '0;
                    case (xfer_q)
                        XF_INIT: begin
                            if (idx_q == 2'd3) begin
                                state_d = IDLE;
                            end else begin
                                idx_d   = idx_q + 2'd1;
                                state_d = INIT_LOAD;
                            end
                        end
                        XF_CHAR: begin
                            if (col_q == COL_W'(COLS - 1)) begin
                                col_d   = '0;
                                line_d  = !line_q;
                                state_d = WRAP_LOAD;
                            end else begin
                                col_d   = col_q + COL_W'(1);
                                state_d = IDLE;
                            end
                        end
                        default: state_d = IDLE;
                    endcase
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WRAP_LOAD: begin
                // line_q already holds the line being moved to.
                rs_d    = 1'b0;
                dat_d   = line_q ? 8'hC0 : 8'h80;
                xfer_d  = XF_CMD;
                state_d = SETUP;
            end
            default: state_d = POWER_WAIT;
        endcase
    end

    assign bus.data_read = (state_q == ACCEPT);
    assign bus.lcd_en    = (state_q == PULSE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.lcd_rs    = rs_q;
    assign bus.lcd_data  = dat_q;
    assign bus.lcd_rw    = 1'b0;

endmodule
